cond_logic_unit: RTL and testbench
==================================

Name: cond_logic_unit

Overview:
- Conditional-execution unit for an ARM-style processor.
- Evaluates the 4-bit condition field of the current instruction against the architectural flags (prevFlags = N,Z,C,V).
- Gates the PC-source, register-write and memory-write strobes with the result.
- Computes and registers the updated flag set (FlagsX). FlagsX is fed back externally as prevFlags on the next instruction.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset
- Cond  input  4  instruction condition field
- ALUFlags  input  4  flags produced by the current ALU op, {N,Z,C,V}
- prevFlags  input  4  current architectural flags {N,Z,C,V}
- FlagW  input  2  flag-write request; [1] updates N,Z, [0] updates C,V
- PCS  input  1  instruction writes PC (branch or PC destination)
- RegW  input  1  instruction writes register file
- MemW  input  1  instruction writes memory
- PCSrc  output  1  PCS gated by CondEx
- RegWrite  output  1  RegW gated by CondEx
- MemWrite  output  1  MemW gated by CondEx
- CondEx  output  1  condition passed
- FlagsX  output  4  registered updated flags {N,Z,C,V}

Behaviour:
- Clock and reset: reset is asynchronous and active-low; clock is clk.
- Flag bit order everywhere: [3]=N, [2]=Z, [1]=C, [0]=V.
- CondEx is combinational from Cond and prevFlags:
  - 0000 EQ: Z; 0001 NE: !Z
  - 0010 CS: C; 0011 CC: !C
  - 0100 MI: N; 0101 PL: !N
  - 0110 VS: V; 0111 VC: !V
  - 1000 HI: C&!Z; 1001 LS: !(C&!Z)
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: !Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1; 1111 (unconditional space): 1
- Strobe outputs are combinational, zero latency: PCSrc=PCS&CondEx; RegWrite=RegW&CondEx; MemWrite=MemW&CondEx.
- Next-flag value, combinational:
  - NZnext = (FlagW[1]&CondEx) ? ALUFlags[3:2] : prevFlags[3:2]
  - CVnext = (FlagW[0]&CondEx) ? ALUFlags[1:0] : prevFlags[1:0]
- FlagsX register: captures {NZnext,CVnext} on every rising clk edge, so it is valid one cycle after inputs are applied. Reset value is 4'b0000.
- Failed condition: no writes and no flag change (FlagsX reloads prevFlags), regardless of PCS/RegW/MemW/FlagW.
- FlagW=11 with CondEx=1 loads all four ALUFlags. FlagW=00 always keeps prevFlags.
- Reset assertion mid-operation clears FlagsX immediately and asynchronously. Combinational outputs keep following their inputs during reset.
- After reset release, the first rising edge loads the next-flag value.
- No X propagation for any legal 4-bit input; all 16 Cond codes are defined.

Test Plan:
- Reset low -> FlagsX=0000 immediately. Release reset, apply Cond=1110, ALUFlags=1010, prevFlags=0000, FlagW=11, PCS=1, RegW=1, MemW=1 -> CondEx=1, PCSrc=RegWrite=MemWrite=1; FlagsX=1010 after next edge.
- Cond=0000 (EQ), prevFlags=0000, FlagW=11, ALUFlags=1111, RegW=1, MemW=1 -> CondEx=0, RegWrite=MemWrite=0; FlagsX=0000 after edge.
- Cond=0000, prevFlags=0100, FlagW=10, ALUFlags=1001, RegW=1 -> CondEx=1, RegWrite=1; FlagsX=1000 (NZ from ALU, CV from prev).
- Cond=1010 (GE): prevFlags=1001 -> CondEx=1; prevFlags=1000 -> CondEx=0. Cond=1100 (GT) with prevFlags=0100 -> 0. Cond=1101 (LE) with prevFlags=0100 -> 1.
- Cond=1000 (HI): prevFlags=0010 -> 1; prevFlags=0110 -> 0. FlagW=01, Cond=1110, ALUFlags=0011, prevFlags=1100 -> FlagsX=1111.
- Sweep all 16 Cond values × 16 prevFlags values against the truth table. Assert reset low mid-sweep -> FlagsX=0000 without waiting for a clock edge.

Source files
------------

// File: rtl/cond_logic_unit.sv
// Conditional-execution unit: evaluates the condition field against the
// architectural flags, gates the write strobes and registers the updated flags.
module cond_logic_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [3:0] prevFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] FlagsX
);

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  logic       n, z, c, v;
  logic [1:0] nz_next, cv_next;

  assign {n, z, c, v} = prevFlags;

  always_comb begin
    CondEx = 1'b0;
    case (cond_t'(Cond))
      EQ: CondEx = z;
      NE: CondEx = ~z;
      CS: CondEx = c;
      CC: CondEx = ~c;
      MI: CondEx = n;
      PL: CondEx = ~n;
      VS: CondEx = v;
      VC: CondEx = ~v;
      HI: CondEx = c & ~z;
      LS: CondEx = ~(c & ~z);
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = ~z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign PCSrc    = PCS  & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;

  assign nz_next = (FlagW[1] & CondEx) ? ALUFlags[3:2] : prevFlags[3:2];
  assign cv_next = (FlagW[0] & CondEx) ? ALUFlags[1:0] : prevFlags[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) FlagsX <= '0;
    else        FlagsX <= {nz_next, cv_next};
  end

endmodule

// File: tb/tb_cond_logic_unit.sv
// Self-checking bench for cond_logic_unit: directed steps, a full Cond x flags
// sweep with a mid-sweep reset, and random steps against a behavioural model.
module tb_cond_logic_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags, prevFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] FlagsX;

  int checks = 0;
  int errors = 0;

  cond_logic_unit dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .prevFlags(prevFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .FlagsX(FlagsX)
  );

  always #5 clk = ~clk;

  // ARM condition semantics: pairs of codes share a predicate, odd code negates it.
  function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
    bit nn, zz, cf, vv, base;
    nn = f[3]; zz = f[2]; cf = f[1]; vv = f[0];
    case (cc[3:1])
      3'd0: base = zz;
      3'd1: base = cf;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = cf && !zz;
      3'd5: base = (nn == vv);
      3'd6: base = !zz && (nn == vv);
      default: return 1'b1;
    endcase
    return cc[0] ? !base : base;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one instruction, check combinational outputs, then FlagsX after the edge.
  task automatic step(input string tag, input logic [3:0] cc, input logic [3:0] alu,
                      input logic [3:0] pf, input logic [1:0] fw,
                      input logic pcs_i, input logic regw_i, input logic memw_i,
                      input bit pulse_reset);
    logic       ex;
    logic [3:0] exp_flags;
    Cond = cc; ALUFlags = alu; prevFlags = pf; FlagW = fw;
    PCS = pcs_i; RegW = regw_i; MemW = memw_i;
    ex = model_cond(cc, pf);
    exp_flags = pf;
    if (ex && fw[1]) exp_flags[3:2] = alu[3:2];
    if (ex && fw[0]) exp_flags[1:0] = alu[1:0];
    #1;
    check({tag, ".CondEx"},   {3'b0, CondEx},   {3'b0, ex});
    check({tag, ".PCSrc"},    {3'b0, PCSrc},    {3'b0, pcs_i & ex});
    check({tag, ".RegWrite"}, {3'b0, RegWrite}, {3'b0, regw_i & ex});
    check({tag, ".MemWrite"}, {3'b0, MemWrite}, {3'b0, memw_i & ex});
    if (pulse_reset) begin
      reset = 1'b0;
      #1;
      check({tag, ".async_reset"}, FlagsX, 4'b0000);
      check({tag, ".CondEx_in_reset"}, {3'b0, CondEx}, {3'b0, ex});
      reset = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, ".FlagsX"}, FlagsX, exp_flags);
  endtask

  initial begin
    reset = 1'b1;
    Cond = '0; ALUFlags = '0; prevFlags = '0; FlagW = '0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    #2 reset = 1'b0;
    #1 check("reset_immediate", FlagsX, 4'b0000);
    @(posedge clk);
    #1 check("reset_held", FlagsX, 4'b0000);
    reset = 1'b1;

    step("al_load_all", 4'b1110, 4'b1010, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    check("al_load_all.literal", FlagsX, 4'b1010);
    step("eq_fail", 4'b0000, 4'b1111, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    check("eq_fail.literal", FlagsX, 4'b0000);
    step("eq_nz_only", 4'b0000, 4'b1001, 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    check("eq_nz_only.literal", FlagsX, 4'b1000);
    step("ge_pass", 4'b1010, 4'b0000, 4'b1001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ge_pass.literal", {3'b0, CondEx}, 4'b0001);
    step("ge_fail", 4'b1010, 4'b0000, 4'b1000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ge_fail.literal", {3'b0, CondEx}, 4'b0000);
    step("gt_fail", 4'b1100, 4'b1111, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    step("le_pass", 4'b1101, 4'b0000, 4'b0100, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    step("hi_pass", 4'b1000, 4'b0000, 4'b0010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step("hi_fail", 4'b1000, 4'b1111, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    step("al_cv_only", 4'b1110, 4'b0011, 4'b1100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("al_cv_only.literal", FlagsX, 4'b1111);
    step("nv_keep", 4'b1111, 4'b0101, 4'b1010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int cc = 0; cc < 16; cc++) begin
      for (int pf = 0; pf < 16; pf++) begin
        step("sweep", 4'(cc), 4'($urandom), 4'(pf), 2'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), (cc == 7 && pf == 9));
      end
    end

    for (int i = 0; i < 64; i++) begin
      step("random", 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
